// File: rtl/rc5_frame_timer_if.sv
// Signal bundle between the RC-5 frame timer and its controller:
// run control, config write channel and the frame strobes.
interface rc5_frame_timer_if #(
   parameter int unsigned CNT_W = 32
);
   logic             en;
   logic             mode;
   logic             trig;
   logic             cfg_wr;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_low;
   logic             cfg_ack;
   logic             cfg_err;
   logic             load_n;
   logic             frame_start;
   logic             half_tick;
   logic             busy;
   logic [CNT_W-1:0] count;

   modport master (
      output en, mode, trig, cfg_wr, cfg_period, cfg_low,
      input  cfg_ack, cfg_err, load_n, frame_start, half_tick, busy, count
   );

   modport slave (
      input  en, mode, trig, cfg_wr, cfg_period, cfg_low,
      output cfg_ack, cfg_err, load_n, frame_start, half_tick, busy, count
   );
endinterface

// File: rtl/rc5_frame_timer.sv
// RC-5 frame-strobe generator: active-low load strobe, frame-start pulse and
// half-bit tick, with shadowed period/low-width config applied at frame start.
module rc5_frame_timer #(
   parameter int unsigned CNT_W           = 32,
   parameter int unsigned PERIOD_CYCLES   = 11379000,
   parameter int unsigned LOW_CYCLES      = 88900,
   parameter int unsigned HALF_BIT_CYCLES = 88900
) (
   input  logic              clk,
   input  logic              rst,
   rc5_frame_timer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TWO        = {{(CNT_W-2){1'b0}}, 2'b10};
   localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(PERIOD_CYCLES);
   localparam logic [CNT_W-1:0] DEF_LOW    = CNT_W'(LOW_CYCLES);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_BIT_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] half_cnt, half_cnt_nxt, half_step;
   logic [CNT_W-1:0] act_period, act_period_nxt, act_low, act_low_nxt;
   logic [CNT_W-1:0] pend_period, pend_period_nxt, pend_low, pend_low_nxt;
   logic             pend_valid, pend_valid_nxt;
   logic             load_n, load_n_nxt, frame_start, frame_start_nxt;
   logic             half_tick, half_tick_nxt, busy, busy_nxt;
   logic             cfg_ack, cfg_ack_nxt, cfg_err, cfg_err_nxt;
   logic             begin_frame, cfg_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         half_cnt    <= '0;
         act_period  <= DEF_PERIOD;
         act_low     <= DEF_LOW;
         pend_period <= '0;
         pend_low    <= '0;
         pend_valid  <= 1'b0;
         load_n      <= 1'b1;
         frame_start <= 1'b0;
         half_tick   <= 1'b0;
         busy        <= 1'b0;
         cfg_ack     <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         half_cnt    <= half_cnt_nxt;
         act_period  <= act_period_nxt;
         act_low     <= act_low_nxt;
         pend_period <= pend_period_nxt;
         pend_low    <= pend_low_nxt;
         pend_valid  <= pend_valid_nxt;
         load_n      <= load_n_nxt;
         frame_start <= frame_start_nxt;
         half_tick   <= half_tick_nxt;
         busy        <= busy_nxt;
         cfg_ack     <= cfg_ack_nxt;
         cfg_err     <= cfg_err_nxt;
      end
   end

   // half_tick is registered from the next half_cnt so it lines up with count
   assign half_step = (half_cnt == HALF_LAST) ? '0 : half_cnt + ONE;
   assign cfg_ok    = (bus.cfg_period >= TWO) && (bus.cfg_low != '0) &&
                      (bus.cfg_low < bus.cfg_period);

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      half_cnt_nxt    = half_cnt;
      act_period_nxt  = act_period;
      act_low_nxt     = act_low;
      pend_period_nxt = pend_period;
      pend_low_nxt    = pend_low;
      pend_valid_nxt  = pend_valid;
      load_n_nxt      = load_n;
      frame_start_nxt = 1'b0;
      half_tick_nxt   = 1'b0;
      busy_nxt        = busy;
      cfg_ack_nxt     = 1'b0;
      cfg_err_nxt     = cfg_err;
      begin_frame     = 1'b0;

      case (state)
         IDLE: begin
            begin_frame = bus.mode ? bus.trig : bus.en;
         end
         LOW: begin
            cnt_nxt       = cnt + ONE;
            half_cnt_nxt  = half_step;
            half_tick_nxt = (half_step == HALF_LAST);
            if (cnt == act_low - ONE) begin
               load_n_nxt = 1'b1;
               state_nxt  = HIGH;
            end
         end
         HIGH: begin
            if (cnt == act_period - ONE) begin
               if (!bus.mode && bus.en) begin
                  begin_frame = 1'b1;
               end else begin
                  state_nxt    = IDLE;
                  cnt_nxt      = '0;
                  half_cnt_nxt = '0;
                  busy_nxt     = 1'b0;
               end
            end else begin
               cnt_nxt       = cnt + ONE;
               half_cnt_nxt  = half_step;
               half_tick_nxt = (half_step == HALF_LAST);
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (begin_frame) begin
         state_nxt       = LOW;
         cnt_nxt         = '0;
         half_cnt_nxt    = '0;
         half_tick_nxt   = (HALF_LAST == '0);
         load_n_nxt      = 1'b0;
         frame_start_nxt = 1'b1;
         busy_nxt        = 1'b1;
         if (pend_valid) begin
            act_period_nxt = pend_period;
            act_low_nxt    = pend_low;
            pend_valid_nxt = 1'b0;
            cfg_ack_nxt    = 1'b1;
         end
      end

      // evaluated after frame start so a coincident write re-arms pending
      if (bus.cfg_wr) begin
         if (cfg_ok) begin
            pend_period_nxt = bus.cfg_period;
            pend_low_nxt    = bus.cfg_low;
            pend_valid_nxt  = 1'b1;
            cfg_err_nxt     = 1'b0;
         end else begin
            cfg_err_nxt = 1'b1;
         end
      end
   end

   assign bus.count       = cnt;
   assign bus.load_n      = load_n;
   assign bus.frame_start = frame_start;
   assign bus.half_tick   = half_tick;
   assign bus.busy        = busy;
   assign bus.cfg_ack     = cfg_ack;
   assign bus.cfg_err     = cfg_err;
endmodule
